// File: rtl/reg_writeback_pkg.sv
// Shared types for the register-file writeback path: load modes, load
// descriptors and the byte-load formatter.
package reg_writeback_pkg;

  localparam int unsigned REG_COUNT = 8;
  localparam int unsigned DATA_W    = 16;
  localparam int unsigned DEST_W    = 3;

  typedef enum logic [1:0] {
    LD_WORD     = 2'b00,
    LD_BYTE_Z   = 2'b01,
    LD_BYTE_S   = 2'b10,
    LD_BYTE_INS = 2'b11
  } ld_mode_e;

  typedef struct packed {
    logic [DEST_W-1:0] dest;
    ld_mode_e          mode;
    logic              lane;
  } ld_desc_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              hb;
    logic              lb;
  } wr_fmt_t;

  // Select the addressed byte lane and extend or insert it according to mode.
  function automatic wr_fmt_t format_load(input ld_desc_t d, input logic [DATA_W-1:0] word);
    logic [7:0] b;
    wr_fmt_t    f;
    b    = d.lane ? word[15:8] : word[7:0];
    f.hb = 1'b1;
    f.lb = 1'b1;
    case (d.mode)
      LD_WORD:   f.data = word;
      LD_BYTE_Z: f.data = {8'h00, b};
      LD_BYTE_S: f.data = {{8{b[7]}}, b};
      default: begin
        f.data = {8'h00, b};
        f.hb   = 1'b0;
      end
    endcase
    return f;
  endfunction

endpackage

// File: rtl/reg_writeback_if.sv
// Bundle of the ALU, load-issue, memory-response and register-file write
// port signals of the writeback stage.
interface reg_writeback_if;
  import reg_writeback_pkg::*;

  logic                 alu_valid;
  logic                 alu_ready;
  logic [DEST_W-1:0]    alu_dest;
  logic [DATA_W-1:0]    alu_data;
  logic                 alu_hb;
  logic                 alu_lb;

  logic                 ld_issue;
  logic                 ld_issue_ready;
  logic [DEST_W-1:0]    ld_dest;
  logic [1:0]           ld_mode;
  logic                 ld_lane;

  logic                 mem_rsp_valid;
  logic                 mem_rsp_ready;
  logic [DATA_W-1:0]    mem_rsp_data;

  logic                 rf_we;
  logic [DEST_W-1:0]    rf_dest;
  logic [DATA_W-1:0]    rf_data;
  logic                 rf_hb;
  logic                 rf_lb;
  logic [REG_COUNT-1:0] busy;

  // Environment side: drives requests, observes write port and busy.
  modport master (
    output alu_valid, alu_dest, alu_data, alu_hb, alu_lb,
    output ld_issue, ld_dest, ld_mode, ld_lane,
    output mem_rsp_valid, mem_rsp_data,
    input  alu_ready, ld_issue_ready, mem_rsp_ready,
    input  rf_we, rf_dest, rf_data, rf_hb, rf_lb, busy
  );

  // Writeback stage side.
  modport slave (
    input  alu_valid, alu_dest, alu_data, alu_hb, alu_lb,
    input  ld_issue, ld_dest, ld_mode, ld_lane,
    input  mem_rsp_valid, mem_rsp_data,
    output alu_ready, ld_issue_ready, mem_rsp_ready,
    output rf_we, rf_dest, rf_data, rf_hb, rf_lb, busy
  );

endinterface

// File: rtl/reg_writeback_pend_fifo.sv
// Pending-load descriptor FIFO. Exposes every entry's valid flag and
// destination so the busy scoreboard can be formed without extra state.
module pend_fifo
  import reg_writeback_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push_i,
  input  logic                          pop_i,
  input  ld_desc_t                      din_i,
  output logic                          full_o,
  output logic                          empty_o,
  output ld_desc_t                      head_o,
  output logic [DEPTH-1:0]              ent_valid_o,
  output logic [DEPTH-1:0][DEST_W-1:0]  ent_dest_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  ld_desc_t      mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push;
  logic          do_pop;
  logic [AW-1:0] off;

  // Fullness uses the current count, so a same-cycle pop does not admit a push.
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Descriptor storage; stale contents are masked by the entry valid flags.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  // An entry is live when its distance from the read pointer is below the count.
  always_comb begin
    off         = '0;
    ent_valid_o = '0;
    ent_dest_o  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      off            = AW'(i) - rd_ptr_q;
      ent_valid_o[i] = (CW'(off) < count_q);
      ent_dest_o[i]  = mem_q[i].dest;
    end
  end

endmodule

// File: rtl/reg_writeback.sv
// Register-file writeback stage: merges ALU results with in-order load
// responses, formats byte loads and tracks registers with pending loads.
module reg_writeback
  import reg_writeback_pkg::*;
#(
  parameter int unsigned PEND_DEPTH = 4
) (
  input logic           clk,
  input logic           reset,
  reg_writeback_if.slave bus
);

  ld_desc_t                         issue_desc;
  ld_desc_t                         head;
  logic                             fifo_full;
  logic                             fifo_empty;
  logic [PEND_DEPTH-1:0]            ent_valid;
  logic [PEND_DEPTH-1:0][DEST_W-1:0] ent_dest;
  logic                             rsp_accept;
  logic                             alu_accept;
  wr_fmt_t                          ld_fmt;

  logic              rf_we_q,     rf_we_d;
  logic [DEST_W-1:0] rf_dest_q,   rf_dest_d;
  logic [DATA_W-1:0] rf_data_q,   rf_data_d;
  logic              rf_hb_q,     rf_hb_d;
  logic              rf_lb_q,     rf_lb_d;
  logic              from_load_q, from_load_d;
  logic [REG_COUNT-1:0] busy_c;

  assign issue_desc = '{dest: bus.ld_dest, mode: ld_mode_e'(bus.ld_mode), lane: bus.ld_lane};

  pend_fifo #(
    .DEPTH (PEND_DEPTH)
  ) u_pend_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (bus.ld_issue),
    .pop_i       (rsp_accept),
    .din_i       (issue_desc),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .head_o      (head),
    .ent_valid_o (ent_valid),
    .ent_dest_o  (ent_dest)
  );

  // Load responses win the write port; the ALU waits while one is accepted.
  assign rsp_accept         = bus.mem_rsp_valid && !fifo_empty;
  assign alu_accept         = bus.alu_valid && !rsp_accept;
  assign bus.mem_rsp_ready  = !fifo_empty;
  assign bus.alu_ready      = !rsp_accept;
  assign bus.ld_issue_ready = !fifo_full;
  assign ld_fmt             = format_load(head, bus.mem_rsp_data);

  // Next write-port contents; non-write cycles hold the previous payload.
  always_comb begin
    rf_we_d     = 1'b0;
    from_load_d = 1'b0;
    rf_dest_d   = rf_dest_q;
    rf_data_d   = rf_data_q;
    rf_hb_d     = rf_hb_q;
    rf_lb_d     = rf_lb_q;
    if (rsp_accept) begin
      rf_we_d     = 1'b1;
      from_load_d = 1'b1;
      rf_dest_d   = head.dest;
      rf_data_d   = ld_fmt.data;
      rf_hb_d     = ld_fmt.hb;
      rf_lb_d     = ld_fmt.lb;
    end else if (alu_accept && (bus.alu_hb || bus.alu_lb)) begin
      rf_we_d     = 1'b1;
      rf_dest_d   = bus.alu_dest;
      rf_data_d   = bus.alu_data;
      rf_hb_d     = bus.alu_hb;
      rf_lb_d     = bus.alu_lb;
    end
  end

  // Registered write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_we_q     <= 1'b0;
      from_load_q <= 1'b0;
      rf_dest_q   <= '0;
      rf_data_q   <= '0;
      rf_hb_q     <= 1'b0;
      rf_lb_q     <= 1'b0;
    end else begin
      rf_we_q     <= rf_we_d;
      from_load_q <= from_load_d;
      rf_dest_q   <= rf_dest_d;
      rf_data_q   <= rf_data_d;
      rf_hb_q     <= rf_hb_d;
      rf_lb_q     <= rf_lb_d;
    end
  end

  // Busy covers queued loads plus a load whose write is on the port right now.
  always_comb begin
    busy_c = '0;
    for (int unsigned p = 0; p < PEND_DEPTH; p++) begin
      if (ent_valid[p]) busy_c[ent_dest[p]] = 1'b1;
    end
    if (rf_we_q && from_load_q) busy_c[rf_dest_q] = 1'b1;
  end

  assign bus.rf_we   = rf_we_q;
  assign bus.rf_dest = rf_dest_q;
  assign bus.rf_data = rf_data_q;
  assign bus.rf_hb   = rf_hb_q;
  assign bus.rf_lb   = rf_lb_q;
  assign bus.busy    = busy_c;

endmodule

// File: doc/reg_writeback.md
Name: reg_writeback

Overview:
- Writer side of the 8x16 register file write port (regDest/dataIn/we/hb/lb).
- Merges single-cycle ALU results with out-of-order-in-time, in-order-returning memory load responses.
- Formats byte loads and drives the byte-enabled write port.
- Keeps a per-register busy scoreboard so decode can stall on pending loads.

Parameters:
- PEND_DEPTH, 4, max outstanding loads; power of two, >=2.

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- alu_valid  in  1  ALU result present
- alu_ready  out  1  ALU result accepted this cycle
- alu_dest  in  3  destination register
- alu_data  in  16  result
- alu_hb  in  1  write high byte
- alu_lb  in  1  write low byte
- ld_issue  in  1  decode issues a load; pushes descriptor
- ld_issue_ready  out  1  descriptor FIFO not full
- ld_dest  in  3  load destination register
- ld_mode  in  2  00 word, 01 byte zero-ext, 10 byte sign-ext, 11 byte insert into low byte
- ld_lane  in  1  byte lane of memory word (0=[7:0], 1=[15:8]); ignored for mode 00
- mem_rsp_valid  in  1  memory read data valid
- mem_rsp_ready  out  1  response accepted
- mem_rsp_data  in  16  memory read word
- rf_we / rf_dest[3] / rf_data[16] / rf_hb / rf_lb  out  to register file write port (registered)
- busy  out  8  bit r set while a load to r is pending or in flight

Behaviour:
- Descriptor FIFO:
  - PEND_DEPTH entries of {dest, mode, lane}.
  - Push on ld_issue && ld_issue_ready.
  - ld_issue_ready = !full. This uses the current count; a same-cycle pop does not free a slot.
  - ld_issue while full is ignored.
- Response acceptance:
  - mem_rsp_ready = FIFO not empty. It is combinational and does not depend on alu_valid.
  - Accept = mem_rsp_valid && mem_rsp_ready. On accept, the FIFO head pops.
  - A push and a pop in the same cycle are both honoured, including push into the slot freed by pop only on the next cycle.
- Arbitration:
  - A load response has strict priority.
  - alu_ready = !(mem_rsp_valid && mem_rsp_ready). The ALU holds its inputs while not ready.
- Load formatting, with b = lane ? data[15:8] : data[7:0]:
  - mode 00: data, hb=lb=1
  - mode 01: {8'h00,b}, hb=lb=1
  - mode 10: {{8{b[7]}},b}, hb=lb=1
  - mode 11: {8'h00,b}, hb=0, lb=1
- Write port:
  - Registered, with 1-cycle latency from the accept edge.
  - rf_we=1 for exactly one cycle per accepted response or ALU result. Otherwise rf_we=0 and the other rf_* outputs hold their last values.
  - An ALU result with alu_hb=alu_lb=0 is accepted but produces rf_we=0.
- Scoreboard:
  - busy[r] = (any valid FIFO entry with dest==r) | (rf_we && rf_dest==r && current write came from a load).
  - Combinational from state, with no input-to-output path.
  - busy[r] stays set until the cycle after the write port asserts. Multiple pending loads to the same r keep it set until the last one writes.
- ALU results do not affect busy. Decode guarantees no ALU write to a busy register.
- Reset:
  - rf_we=0, rf_dest=0, rf_data=0, rf_hb=0, rf_lb=0.
  - FIFO empty, busy=8'h00, ld_issue_ready=1, mem_rsp_ready=0.
  - Reset mid-operation drops all pending descriptors. Responses arriving after reset with an empty FIFO are not accepted.
- mem_rsp_valid with an empty FIFO is not accepted and causes no write.

Decomposition:
- Shared package:
  - LD_WORD/LD_BYTE_Z/LD_BYTE_S/LD_BYTE_INS mode constants
  - load-descriptor struct {dest[2:0], mode[1:0], lane}
  - REG_COUNT=8, DATA_W=16
- One sub-module: pend_fifo, a synchronous FIFO with parameter depth.
  - Exposes full, empty, head, and a per-entry valid+dest vector for the scoreboard.

Test Plan:
- ALU only:
  - Stimulus: alu_valid, dest=3, data=16'hBEEF, hb=lb=1.
  - Required: alu_ready=1; next cycle rf_we=1, rf_dest=3, rf_data=BEEF, rf_hb=rf_lb=1; busy stays 0.
- Sign-extended byte load:
  - Stimulus: issue dest=5, mode=10, lane=1. Two cycles later mem_rsp_data=16'h80A5.
  - Required: busy[5]=1 from the cycle after issue. Write rf_data=16'hFF80, hb=lb=1. busy[5] clears the cycle after rf_we.
- Byte insert:
  - Stimulus: mode 11, lane 0, response 16'h1234.
  - Required: rf_data=16'h0034, rf_hb=0, rf_lb=1.
- Collision:
  - Stimulus: alu_valid and mem_rsp_valid in the same cycle.
  - Required: alu_ready=0 that cycle and the load writes first. ALU is accepted the next cycle and writes one cycle after the load.
- Back-pressure:
  - Stimulus: 4 issues with no responses.
  - Required: ld_issue_ready=0. A 5th issue is ignored. 4 in-order responses write dests in issue order. A double load to the same dest keeps busy set until the second write.
- Reset mid-flight:
  - Stimulus: 2 loads pending, assert reset for one cycle.
  - Required: busy=0, mem_rsp_ready=0. A late response causes no rf_we.
